// File: rtl/bpu_update_sched.sv
// rtl/bpu_update_sched.sv - branch predictor table-clear sweep and update FIFO scheduler
// Optional feature macro: BPU_UPD_BYPASS_EN (same-cycle write of a push into an idle, empty FIFO)
module bpu_update_sched #(
    parameter int PC_W  = 64,
    parameter int IDX_W = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [PC_W-1:0]          res_pc,
    input  logic                     res_jump,
    input  logic [1:0]               res_jumptype,
    input  logic [PC_W-1:0]          res_target,
    input  logic                     flush,
    input  logic                     upd_hold,
    output logic                     predict_en,
    output logic                     dir_we,
    output logic [IDX_W-1:0]         dir_idx,
    output logic                     dir_taken,
    output logic                     tgt_we,
    output logic [IDX_W-1:0]         tgt_idx,
    output logic [PC_W-IDX_W-3:0]    tgt_tag,
    output logic [PC_W-1:0]          tgt_target,
    output logic [1:0]               tgt_type,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sweep_idx_q, sweep_idx_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               predict_en_q, predict_en_d;
    logic               dir_we_q, dir_we_d;
    logic [IDX_W-1:0]   dir_idx_q, dir_idx_d;
    logic               dir_taken_q, dir_taken_d;
    logic               tgt_we_q, tgt_we_d;
    logic [IDX_W-1:0]   tgt_idx_q, tgt_idx_d;
    logic [TAG_W-1:0]   tgt_tag_q, tgt_tag_d;
    logic [PC_W-1:0]    tgt_target_q, tgt_target_d;
    logic [1:0]         tgt_type_q, tgt_type_d;

    // FIFO storage keeps only pc[PC_W-1:2]; the byte offset never reaches the tables
    logic [PC_W-3:0]    fifo_pc_q     [DEPTH];
    logic               fifo_jump_q   [DEPTH];
    logic [1:0]         fifo_type_q   [DEPTH];
    logic [PC_W-1:0]    fifo_target_q [DEPTH];

    logic               unused_pc_lsb;
    logic               ready;
    logic               byp;
    logic               push;
    logic               pop;
    logic [PC_W-3:0]    head_pc;

    assign unused_pc_lsb = ^res_pc[1:0];
    assign ready   = (count_q != DEPTH_C);
    assign head_pc = fifo_pc_q[rd_ptr_q];

`ifdef BPU_UPD_BYPASS_EN
    // Idle, empty queue and no registered write in flight: send the push straight through
    assign byp = (state_q == ST_RUN) && (count_q == '0) && !upd_hold && !flush
                 && res_valid && !dir_we_q;
`else
    assign byp = 1'b0;
`endif

    // A full FIFO has ready low, so a same-cycle pop never lets a push in
    assign push = res_valid && ready && !flush && !byp;
    assign pop  = (state_q == ST_RUN) && (count_q != '0) && !upd_hold && !flush;

    // State, sweep index, queue pointers and registered write ports
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            sweep_idx_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            predict_en_q <= 1'b0;
            dir_we_q     <= 1'b0;
            dir_idx_q    <= '0;
            dir_taken_q  <= 1'b0;
            tgt_we_q     <= 1'b0;
            tgt_idx_q    <= '0;
            tgt_tag_q    <= '0;
            tgt_target_q <= '0;
            tgt_type_q   <= '0;
        end else begin
            state_q      <= state_d;
            sweep_idx_q  <= sweep_idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            predict_en_q <= predict_en_d;
            dir_we_q     <= dir_we_d;
            dir_idx_q    <= dir_idx_d;
            dir_taken_q  <= dir_taken_d;
            tgt_we_q     <= tgt_we_d;
            tgt_idx_q    <= tgt_idx_d;
            tgt_tag_q    <= tgt_tag_d;
            tgt_target_q <= tgt_target_d;
            tgt_type_q   <= tgt_type_d;
        end
    end

    // Queue payload storage; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]     <= res_pc[PC_W-1:2];
            fifo_jump_q[wr_ptr_q]   <= res_jump;
            fifo_type_q[wr_ptr_q]   <= res_jumptype;
            fifo_target_q[wr_ptr_q] <= res_target;
        end
    end

    // Next state: sweep every index once, then stay in RUN until reset
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        if (state_q == ST_INIT) begin
            sweep_idx_d = sweep_idx_q + IDX_W'(1);
            if (sweep_idx_q == {IDX_W{1'b1}}) begin
                state_d = ST_RUN;
            end
        end
    end

    // Queue bookkeeping; flush wins over push and pop in the same cycle
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Next write-port values: clear writes during the sweep, popped entry afterwards
    always_comb begin
        predict_en_d = (state_d == ST_RUN);
        dir_we_d     = 1'b0;
        dir_idx_d    = '0;
        dir_taken_d  = 1'b0;
        tgt_we_d     = 1'b0;
        tgt_idx_d    = '0;
        tgt_tag_d    = '0;
        tgt_target_d = '0;
        tgt_type_d   = '0;
        if (state_q == ST_INIT) begin
            dir_we_d  = 1'b1;
            tgt_we_d  = 1'b1;
            dir_idx_d = sweep_idx_q;
            tgt_idx_d = sweep_idx_q;
        end else if (pop) begin
            // Jumptype 00 entries drain silently without touching either table
            dir_we_d     = (fifo_type_q[rd_ptr_q] != 2'b00);
            tgt_we_d     = fifo_jump_q[rd_ptr_q] && (fifo_type_q[rd_ptr_q] != 2'b00);
            dir_idx_d    = head_pc[IDX_W-1:0];
            dir_taken_d  = fifo_jump_q[rd_ptr_q];
            tgt_idx_d    = head_pc[IDX_W-1:0];
            tgt_tag_d    = head_pc[PC_W-3:IDX_W];
            tgt_target_d = fifo_target_q[rd_ptr_q];
            tgt_type_d   = fifo_type_q[rd_ptr_q];
        end
    end

    // Drive write ports from registers, or from the incoming resolution when bypassing
    always_comb begin
        dir_we     = dir_we_q;
        dir_idx    = dir_idx_q;
        dir_taken  = dir_taken_q;
        tgt_we     = tgt_we_q;
        tgt_idx    = tgt_idx_q;
        tgt_tag    = tgt_tag_q;
        tgt_target = tgt_target_q;
        tgt_type   = tgt_type_q;
`ifdef BPU_UPD_BYPASS_EN
        if (byp) begin
            dir_we     = (res_jumptype != 2'b00);
            dir_idx    = res_pc[IDX_W+1:2];
            dir_taken  = res_jump;
            tgt_we     = res_jump && (res_jumptype != 2'b00);
            tgt_idx    = res_pc[IDX_W+1:2];
            tgt_tag    = res_pc[PC_W-1:IDX_W+2];
            tgt_target = res_target;
            tgt_type   = res_jumptype;
        end
`endif
    end

    assign res_ready  = ready;
    assign predict_en = predict_en_q;
    assign q_count    = count_q;

endmodule

// File: tb/tb_bpu_update_sched.sv
// tb/tb_bpu_update_sched.sv - directed self-checking bench for bpu_update_sched
module tb_bpu_update_sched;

    logic        clock;
    logic        reset;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_pc;
    logic        res_jump;
    logic [1:0]  res_jumptype;
    logic [63:0] res_target;
    logic        flush;
    logic        upd_hold;
    logic        predict_en;
    logic        dir_we;
    logic [5:0]  dir_idx;
    logic        dir_taken;
    logic        tgt_we;
    logic [5:0]  tgt_idx;
    logic [55:0] tgt_tag;
    logic [63:0] tgt_target;
    logic [1:0]  tgt_type;
    logic [2:0]  q_count;

    int total = 0;
    int bad   = 0;

    bpu_update_sched #(.PC_W(64), .IDX_W(6), .DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
        .res_jump(res_jump), .res_jumptype(res_jumptype), .res_target(res_target),
        .flush(flush), .upd_hold(upd_hold), .predict_en(predict_en),
        .dir_we(dir_we), .dir_idx(dir_idx), .dir_taken(dir_taken),
        .tgt_we(tgt_we), .tgt_idx(tgt_idx), .tgt_tag(tgt_tag),
        .tgt_target(tgt_target), .tgt_type(tgt_type), .q_count(q_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic j,
                         input logic [1:0] t, input logic [63:0] tg);
        res_valid    = v;
        res_pc       = pc;
        res_jump     = j;
        res_jumptype = t;
        res_target   = tg;
    endtask

    initial begin
        reset    = 1'b0;
        flush    = 1'b0;
        upd_hold = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 2'b00, 64'h0);

        // Reset state
        #12;
        chk("rst_strobes", 64'({dir_we, tgt_we, predict_en}), 64'h0);
        chk("rst_ready", 64'(res_ready), 64'h1);
        chk("rst_count", 64'(q_count), 64'h0);

        // Table-clear sweep
        #10 reset = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step();
            chk("sweep", 64'({dir_we, tgt_we, dir_taken, tgt_type, dir_idx, tgt_idx}),
                64'({3'b110, 2'b00, 6'(i), 6'(i)}));
            if (i == 0) chk("sweep_pred_off", 64'(predict_en), 64'h0);
        end
        chk("sweep_tgt_zero", {tgt_target[31:0], tgt_tag[31:0]}, 64'h0);
        chk("pred_on", 64'(predict_en), 64'h1);
        step();
        chk("idle_no_strobe", 64'({dir_we, tgt_we}), 64'h0);

`ifndef BPU_UPD_BYPASS_EN
        // Single resolution, one-cycle latency
        drive(1'b1, 64'h8000_0010, 1'b1, 2'b01, 64'h8000_0100);
        step();
        drive(1'b0, 64'h0, 1'b0, 2'b00, 64'h0);
        chk("one_queued", 64'({dir_we, q_count}), 64'h1);
        step();
        chk("one_dir", 64'({dir_we, dir_idx, dir_taken}), 64'({1'b1, 6'd4, 1'b1}));
        chk("one_tgt", 64'({tgt_we, tgt_idx, tgt_type}), 64'({1'b1, 6'd4, 2'b01}));
        chk("one_target", tgt_target, 64'h8000_0100);
        chk("one_tag", 64'(tgt_tag), 64'h80_0000);
        step();
        chk("one_done", 64'({dir_we, tgt_we, q_count}), 64'h0);
`else
        // Bypass: empty, idle queue writes in the same cycle
        drive(1'b1, 64'h8000_0010, 1'b1, 2'b01, 64'h8000_0100);
        #1;
        chk("byp_dir", 64'({dir_we, dir_idx, dir_taken}), 64'({1'b1, 6'd4, 1'b1}));
        chk("byp_tgt", 64'({tgt_we, tgt_idx, tgt_type}), 64'({1'b1, 6'd4, 2'b01}));
        chk("byp_target", tgt_target, 64'h8000_0100);
        step();
        drive(1'b0, 64'h0, 1'b0, 2'b00, 64'h0);
        chk("byp_not_queued", 64'({dir_we, tgt_we, q_count}), 64'h0);
`endif

        // Hold with five pushes: only DEPTH accepted
        upd_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'h20 + 64'(4 * i), 1'b1, 2'b01, 64'h1020 + 64'(4 * i));
            step();
        end
        drive(1'b0, 64'h0, 1'b0, 2'b00, 64'h0);
        chk("full_count", 64'(q_count), 64'h4);
        chk("full_ready", 64'(res_ready), 64'h0);
        chk("hold_no_strobe", 64'(dir_we), 64'h0);

        // Release hold with a push offered while full: pop happens, push does not
        upd_hold = 1'b0;
        drive(1'b1, 64'h3C, 1'b1, 2'b01, 64'h103C);
        step();
        drive(1'b0, 64'h0, 1'b0, 2'b00, 64'h0);
        chk("drain0", 64'({dir_we, dir_idx, tgt_target[15:0]}), 64'({1'b1, 6'd8, 16'h1020}));
        chk("full_pop_no_push", 64'(q_count), 64'h3);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("drain", 64'({dir_we, tgt_we, dir_idx, tgt_target[15:0]}),
                64'({2'b11, 6'(8 + i), 16'h1020 + 16'(4 * i)}));
        end
        step();
        chk("drain_done", 64'({dir_we, q_count}), 64'h0);

        // Not-taken branch trains direction only; jumptype 00 writes nothing
        upd_hold = 1'b1;
        drive(1'b1, 64'h40, 1'b0, 2'b01, 64'h2000);
        step();
        drive(1'b1, 64'h44, 1'b1, 2'b00, 64'h3000);
        step();
        drive(1'b0, 64'h0, 1'b0, 2'b00, 64'h0);
        chk("nt_queued", 64'(q_count), 64'h2);
        upd_hold = 1'b0;
        step();
        chk("nt_strobe", 64'({dir_we, dir_taken, tgt_we, dir_idx}), 64'({3'b100, 6'd16}));
        step();
        chk("none_no_strobe", 64'({dir_we, tgt_we, q_count}), 64'h0);

        // Flush with concurrent push and pending pop
        upd_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h60 + 64'(4 * i), 1'b1, 2'b10, 64'h4000);
            step();
        end
        drive(1'b0, 64'h0, 1'b0, 2'b00, 64'h0);
        chk("pre_flush_count", 64'(q_count), 64'h3);
        flush    = 1'b1;
        upd_hold = 1'b0;
        drive(1'b1, 64'h70, 1'b1, 2'b01, 64'h5000);
        step();
        flush = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 2'b00, 64'h0);
        chk("flush_count", 64'({dir_we, tgt_we, q_count}), 64'h0);
        step();
        chk("post_flush", 64'({dir_we, tgt_we, q_count}), 64'h0);

        // Reset in the middle of a second sweep
        reset = 1'b0;
        #3 reset = 1'b1;
        for (int i = 0; i < 21; i++) step();
        chk("sweep2_at20", 64'({dir_we, dir_idx}), 64'({1'b1, 6'd20}));
        #2 reset = 1'b0;
        #1;
        chk("midrst_strobes", 64'({dir_we, tgt_we, predict_en, dir_idx}), 64'h0);
        chk("midrst_ready", 64'(res_ready), 64'h1);
        @(negedge clock);
        reset = 1'b1;
        step();
        chk("restart_idx0", 64'({dir_we, tgt_we, dir_idx, predict_en}), 64'({2'b11, 6'd0, 1'b0}));
        for (int i = 0; i < 63; i++) step();
        chk("restart_end", 64'({dir_we, dir_idx, predict_en}), 64'({1'b1, 6'd63, 1'b1}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
